tetris_sequencer: RTL

Central game-flow controller for the FPGA Tetris design. It collects debounced button pulses and the gravity tick, and serialises them into one move request at a time for the collision checker. On a failed downward move it sequences lock, line-clear and spawn through handshakes with the map and piece generator. It also owns the `playing`/`gameover` status and the cleared-line total that feeds the score display.

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/tetris_req_latch.sv | 115 +++++++++++
 rtl/tetris_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared definitions for the Tetris game-flow sequencer.
//   - req_op encodings driven toward the collision checker
//   - sequencer state enumeration
//   - LINES_W: width of the cleared-line total
package tetris_pkg;

    localparam int LINES_W = 14;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_ROT   = 3'd4;
    localparam logic [2:0] OP_SPAWN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SPAWN = 3'd2,
        S_PLAY  = 3'd3,
        S_MOVE  = 3'd4,
        S_LOCK  = 3'd5,
        S_CLEAR = 3'd6,
        S_OVER  = 3'd7
    } state_t;

endpackage

// File: rtl/tetris_req_latch.sv
// tetris_req_latch: pending-request latch for the Tetris sequencer.
// Holds one pending bit per move source, merges tick/btn_down into a single
// DOWN request (tagged gravity if a tick contributed), and presents the
// highest-priority pending request. The granted bit is cleared on grant.
// Optional feature macro: TETRIS_HARD_DROP_EN (adds the hard-drop flag,
// priority just below ROTATE).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   capture             accept incoming pulses this cycle
//   flush               discard everything pending
//   grant               the presented request is being taken this cycle
//   btn_*, tick         single-cycle input pulses
//   pending             some request is pending
//   op                  presented request (OP_* encoding)
//   grav                presented DOWN came from gravity
//   drop                presented DOWN is a hard drop
module tetris_req_latch
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       flush,
    input  logic       grant,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_turn,
    input  logic       btn_drop,
    input  logic       tick,
    output logic       pending,
    output logic [2:0] op,
    output logic       grav,
    output logic       drop
);

    logic p_left, p_right, p_down, p_rot, p_grav;
`ifdef TETRIS_HARD_DROP_EN
    logic p_drop;
`else
    logic unused_drop;
    assign unused_drop = btn_drop;
`endif

    // Fixed priority: ROTATE > (DROP) > LEFT > RIGHT > DOWN
    always_comb begin
        op   = OP_NONE;
        grav = 1'b0;
        drop = 1'b0;
        if (p_rot) begin
            op = OP_ROT;
        end
`ifdef TETRIS_HARD_DROP_EN
        else if (p_drop) begin
            op   = OP_DOWN;
            drop = 1'b1;
        end
`endif
        else if (p_left) begin
            op = OP_LEFT;
        end else if (p_right) begin
            op = OP_RIGHT;
        end else if (p_down) begin
            op   = OP_DOWN;
            grav = p_grav;
        end
    end

    assign pending = (op != OP_NONE);

    // New pulses are applied after the grant clear, so a pulse landing in
    // the grant cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            p_left  <= 1'b0;
            p_right <= 1'b0;
            p_down  <= 1'b0;
            p_rot   <= 1'b0;
            p_grav  <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
            p_drop  <= 1'b0;
`endif
        end else begin
            if (grant) begin
                case (op)
                    OP_ROT:   p_rot   <= 1'b0;
                    OP_LEFT:  p_left  <= 1'b0;
                    OP_RIGHT: p_right <= 1'b0;
                    OP_DOWN: begin
`ifdef TETRIS_HARD_DROP_EN
                        if (drop) p_drop <= 1'b0;
                        else
`endif
                        begin
                            p_down <= 1'b0;
                            p_grav <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (capture) begin
                if (btn_turn)            p_rot   <= 1'b1;
                if (btn_left)            p_left  <= 1'b1;
                if (btn_right)           p_right <= 1'b1;
                if (tick || btn_down)    p_down  <= 1'b1;
                if (tick)                p_grav  <= 1'b1;
`ifdef TETRIS_HARD_DROP_EN
                if (btn_drop)            p_drop  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/tetris_sequencer.sv
// tetris_sequencer: central game-flow controller. Serialises button/gravity
// pulses into one checker request at a time, sequences lock -> line-clear ->
// spawn on a failed downward move, and owns playing/gameover and the
// saturating cleared-line total.
// Optional feature macro: TETRIS_HARD_DROP_EN (btn_drop hard drop).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         start / restart pulse
//   btn_left/right/down/turn/drop button pulses; tick = gravity pulse
//   req_valid, req_op             request to the checker (level until done)
//   chk_done, chk_ok              checker completion and result
//   lock_req / lock_done          merge handshake with the map
//   clear_req / clear_done        line-clear handshake; clear_lines = rows
//   board_clr                     one-cycle map wipe pulse
//   playing, gameover             game status
//   lines_total                   cumulative cleared lines (saturating)
module tetris_sequencer
    import tetris_pkg::*;
#(
    parameter int LOCK_TICKS = 1,
    parameter int SCORE_MAX  = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               btn_turn,
    input  logic               btn_drop,
    input  logic               tick,
    output logic               req_valid,
    output logic [2:0]         req_op,
    input  logic               chk_done,
    input  logic               chk_ok,
    output logic               lock_req,
    input  logic               lock_done,
    output logic               clear_req,
    input  logic               clear_done,
    input  logic [2:0]         clear_lines,
    output logic               board_clr,
    output logic               playing,
    output logic               gameover,
    output logic [LINES_W-1:0] lines_total
);

    state_t     state;
    logic [2:0] fail_cnt;
    logic       cur_grav;
    logic       cur_drop;
    logic       sel_pending, sel_grav, sel_drop;
    logic [2:0] sel_op;
    logic       restartable;

    function automatic logic [LINES_W-1:0] sat_add(input logic [LINES_W-1:0] a,
                                                   input logic [2:0] b);
        logic [LINES_W:0] s;
        s = {1'b0, a} + {{(LINES_W-2){1'b0}}, b};
        if (s > (LINES_W+1)'(SCORE_MAX)) return LINES_W'(SCORE_MAX);
        return s[LINES_W-1:0];
    endfunction

    assign restartable = (state != S_CLR) && (state != S_SPAWN);

    tetris_req_latch u_latch (
        .clk       (clk),
        .rst       (rst),
        .capture   ((state == S_PLAY) || (state == S_MOVE)),
        // Nothing is captured in CLR/CLEAR, so flushing there equals
        // clearing on the way into SPAWN.
        .flush     ((state == S_CLR) || (state == S_CLEAR)),
        .grant     ((state == S_PLAY) && sel_pending && !start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_turn  (btn_turn),
        .btn_drop  (btn_drop),
        .tick      (tick),
        .pending   (sel_pending),
        .op        (sel_op),
        .grav      (sel_grav),
        .drop      (sel_drop)
    );

    // Request/handshake outputs rise on the first cycle of their waiting
    // state; done inputs are only honoured while the request is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_valid   <= 1'b0;
            req_op      <= OP_NONE;
            lock_req    <= 1'b0;
            clear_req   <= 1'b0;
            board_clr   <= 1'b0;
            playing     <= 1'b0;
            gameover    <= 1'b0;
            lines_total <= '0;
            fail_cnt    <= '0;
            cur_grav    <= 1'b0;
            cur_drop    <= 1'b0;
        end else begin
            board_clr <= 1'b0;
            if (start && restartable) begin
                state       <= S_CLR;
                board_clr   <= 1'b1;
                lines_total <= '0;
                gameover    <= 1'b0;
                playing     <= 1'b0;
                req_valid   <= 1'b0;
                lock_req    <= 1'b0;
                clear_req   <= 1'b0;
                fail_cnt    <= '0;
                cur_drop    <= 1'b0;
            end else begin
                case (state)
                    S_CLR: begin
                        state   <= S_SPAWN;
                        req_op  <= OP_SPAWN;
                        playing <= 1'b1;
                    end
                    S_SPAWN: begin
                        if (!req_valid) begin
                            req_valid <= 1'b1;
                        end else if (chk_done) begin
                            req_valid <= 1'b0;
                            if (chk_ok) begin
                                state <= S_PLAY;
                            end else begin
                                state    <= S_OVER;
                                gameover <= 1'b1;
                                playing  <= 1'b0;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (sel_pending) begin
                            state    <= S_MOVE;
                            req_op   <= sel_op;
                            cur_grav <= sel_grav;
                            cur_drop <= sel_drop;
                        end
                    end
                    S_MOVE: begin
                        if (!req_valid) begin
                            req_valid <= 1'b1;
                        end else if (chk_done) begin
                            req_valid <= 1'b0;
                            if (req_op != OP_DOWN) begin
                                state <= S_PLAY;
                            end else if (chk_ok) begin
                                fail_cnt <= '0;
                                // A hard drop keeps reissuing DOWN from MOVE.
                                state    <= cur_drop ? S_MOVE : S_PLAY;
                            end else if (cur_drop || !cur_grav ||
                                         (fail_cnt + 3'd1) >= 3'(LOCK_TICKS)) begin
                                fail_cnt <= '0;
                                cur_drop <= 1'b0;
                                state    <= S_LOCK;
                            end else begin
                                fail_cnt <= fail_cnt + 3'd1;
                                state    <= S_PLAY;
                            end
                        end
                    end
                    S_LOCK: begin
                        if (!lock_req) begin
                            lock_req <= 1'b1;
                        end else if (lock_done) begin
                            lock_req <= 1'b0;
                            state    <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        if (!clear_req) begin
                            clear_req <= 1'b1;
                        end else if (clear_done) begin
                            clear_req   <= 1'b0;
                            lines_total <= sat_add(lines_total, clear_lines);
                            state       <= S_SPAWN;
                            req_op      <= OP_SPAWN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
